// File: rtl/axis_sync_fifo_pkt.sv
// -----------------------------------------------------------------------------
// axis_sync_fifo_pkt
//
// Synchronous AXI-Stream FIFO with an arbitrary (not power-of-two) depth,
// tlast carriage, an occupancy count, almost-full/almost-empty flags and a
// single-cycle flush. The slave side (sif_*) faces the producer and the master
// side (mif_*) faces the consumer. There is no fall-through path: a word pushed
// at one clock edge is presented on mif_* starting in the next cycle.
//
// Optional build macro: AXIS_FIFO_PKT_MODE_EN
//   Defined   : packet mode. mif_tvalid is held low until at least one
//               complete packet (a word with tlast=1) is buffered, or until
//               the FIFO is full. The full case keeps packets longer than
//               DEPTH from deadlocking.
//   Undefined : word mode. Any buffered word is presented immediately.
//
// Parameters
//   TDATA_WIDTH   payload width in bits (>=1)
//   DEPTH         number of entries (>=2, any integer)
//   AFULL_THRESH  almost_full  when count >= AFULL_THRESH (1..DEPTH)
//   AEMPTY_THRESH almost_empty when count <= AEMPTY_THRESH (0..DEPTH-1)
//   CNT_WIDTH     derived occupancy width, $clog2(DEPTH+1)
//
// Ports
//   clk           clock
//   rst           synchronous active-high reset
//   sif_tvalid    producer data valid
//   sif_tdata     producer payload
//   sif_tlast     producer end-of-packet
//   sif_tready    FIFO can accept (independent of mif_tready)
//   mif_tvalid    FIFO head valid
//   mif_tdata     head payload (don't-care while mif_tvalid=0)
//   mif_tlast     head end-of-packet (don't-care while mif_tvalid=0)
//   mif_tready    consumer accepts
//   invalidate    flush all contents; blocks push and pop while high
//   count         current occupancy
//   almost_full   count >= AFULL_THRESH
//   almost_empty  count <= AEMPTY_THRESH
// -----------------------------------------------------------------------------
module axis_sync_fifo_pkt #(
   parameter  int TDATA_WIDTH   = 32,
   parameter  int DEPTH         = 8,
   parameter  int AFULL_THRESH  = DEPTH - 1,
   parameter  int AEMPTY_THRESH = 1,
   localparam int CNT_WIDTH     = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   sif_tvalid,
   input  logic [TDATA_WIDTH-1:0] sif_tdata,
   input  logic                   sif_tlast,
   output logic                   sif_tready,
   output logic                   mif_tvalid,
   output logic [TDATA_WIDTH-1:0] mif_tdata,
   output logic                   mif_tlast,
   input  logic                   mif_tready,
   input  logic                   invalidate,
   output logic [CNT_WIDTH-1:0]   count,
   output logic                   almost_full,
   output logic                   almost_empty
);

   localparam int                   PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W-1:0]     PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [PTR_W-1:0]     PTR_ZERO = '0;
   localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_AF   = CNT_WIDTH'(AFULL_THRESH);
   localparam logic [CNT_WIDTH-1:0] CNT_AE   = CNT_WIDTH'(AEMPTY_THRESH);

   // Each entry holds {tlast, tdata}.
   logic [TDATA_WIDTH:0] mem [DEPTH];

   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [CNT_WIDTH-1:0] count_r;

   logic                 push;
   logic                 pop;
   logic [PTR_W-1:0]     wr_ptr_nxt;
   logic [PTR_W-1:0]     rd_ptr_nxt;

   // Explicit wrap so that any DEPTH works, not just powers of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? PTR_ZERO : p + PTR_ONE;
   endfunction

   assign wr_ptr_nxt = ptr_inc(wr_ptr);
   assign rd_ptr_nxt = ptr_inc(rd_ptr);

   // A full FIFO refuses the producer even if the consumer pops this cycle,
   // which keeps sif_tready free of any path from mif_tready.
   assign sif_tready = (count_r != CNT_FULL) & ~invalidate;

`ifdef AXIS_FIFO_PKT_MODE_EN
   // Number of buffered words that carry tlast, i.e. complete packets held.
   logic [CNT_WIDTH-1:0] pkt_cnt;
   logic                 pkt_in;
   logic                 pkt_out;

   assign pkt_in  = push & sif_tlast;
   assign pkt_out = pop & mif_tlast;

   always_ff @(posedge clk) begin
      if (rst || invalidate) begin
         pkt_cnt <= CNT_ZERO;
      end else begin
         case ({pkt_in, pkt_out})
            2'b10:   pkt_cnt <= pkt_cnt + CNT_ONE;
            2'b01:   pkt_cnt <= pkt_cnt - CNT_ONE;
            default: pkt_cnt <= pkt_cnt;
         endcase
      end
   end

   // Release once a whole packet is stored, or when full so that an
   // over-long packet can still drain.
   assign mif_tvalid = (count_r != CNT_ZERO) &
                       ((pkt_cnt != CNT_ZERO) | (count_r == CNT_FULL)) &
                       ~invalidate;
`else
   assign mif_tvalid = (count_r != CNT_ZERO) & ~invalidate;
`endif

   assign push = sif_tvalid & sif_tready;
   assign pop  = mif_tvalid & mif_tready;

   assign {mif_tlast, mif_tdata} = mem[rd_ptr];

   // Storage is not reset; the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {sif_tlast, sif_tdata};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= PTR_ZERO;
         rd_ptr  <= PTR_ZERO;
         count_r <= CNT_ZERO;
      end else if (invalidate) begin
         // Flush by collapsing the read pointer onto the write pointer.
         rd_ptr  <= wr_ptr;
         count_r <= CNT_ZERO;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr_nxt;
         end
         if (pop) begin
            rd_ptr <= rd_ptr_nxt;
         end
         case ({push, pop})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   assign count        = count_r;
   assign almost_full  = (count_r >= CNT_AF);
   assign almost_empty = (count_r <= CNT_AE);

endmodule

// File: tb/tb_axis_sync_fifo_pkt.sv
// -----------------------------------------------------------------------------
// tb_axis_sync_fifo_pkt
//
// Bench for axis_sync_fifo_pkt. A queue-based reference model tracks the FIFO
// contents and is compared against the DUT every cycle; a directed sequence
// drives the scenarios and pins key values with literal expectations. Word
// mode is exercised at DEPTH=5; packet mode (AXIS_FIFO_PKT_MODE_EN) at DEPTH=8.
// -----------------------------------------------------------------------------
module tb_axis_sync_fifo_pkt;

`ifdef AXIS_FIFO_PKT_MODE_EN
   localparam int DEPTH = 8;
   localparam bit PKT   = 1'b1;
`else
   localparam int DEPTH = 5;
   localparam bit PKT   = 1'b0;
`endif
   localparam int W      = 16;
   localparam int AF     = DEPTH - 1;
   localparam int AE     = 1;
   localparam int CW     = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          sif_tvalid;
   logic [W-1:0]  sif_tdata;
   logic          sif_tlast;
   logic          sif_tready;
   logic          mif_tvalid;
   logic [W-1:0]  mif_tdata;
   logic          mif_tlast;
   logic          mif_tready;
   logic          invalidate;
   logic [CW-1:0] count;
   logic          almost_full;
   logic          almost_empty;

   int pass_cnt  = 0;
   int total_cnt = 0;

   axis_sync_fifo_pkt #(
      .TDATA_WIDTH  (W),
      .DEPTH        (DEPTH),
      .AFULL_THRESH (AF),
      .AEMPTY_THRESH(AE)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sif_tvalid  (sif_tvalid),
      .sif_tdata   (sif_tdata),
      .sif_tlast   (sif_tlast),
      .sif_tready  (sif_tready),
      .mif_tvalid  (mif_tvalid),
      .mif_tdata   (mif_tdata),
      .mif_tlast   (mif_tlast),
      .mif_tready  (mif_tready),
      .invalidate  (invalidate),
      .count       (count),
      .almost_full (almost_full),
      .almost_empty(almost_empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   logic [W:0] q[$];
   bit         model_ok = 1'b0;

   function automatic int n_last();
      int n = 0;
      foreach (q[i]) if (q[i][W]) n++;
      return n;
   endfunction

   always @(negedge clk) begin
      bit e_rdy, e_vld, do_push, do_pop;
      if (rst) begin
         q.delete();
         model_ok = 1'b1;
      end else if (model_ok) begin
         e_rdy = (q.size() != DEPTH) && !invalidate;
         e_vld = (q.size() != 0) && !invalidate &&
                 (!PKT || n_last() != 0 || q.size() == DEPTH);
         chk("m_sif_tready",   32'(sif_tready),   32'(e_rdy));
         chk("m_mif_tvalid",   32'(mif_tvalid),   32'(e_vld));
         chk("m_count",        32'(count),        32'(q.size()));
         chk("m_almost_full",  32'(almost_full),  32'(q.size() >= AF));
         chk("m_almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
         if (e_vld) begin
            chk("m_mif_tdata", 32'(mif_tdata), 32'(q[0][W-1:0]));
            chk("m_mif_tlast", 32'(mif_tlast), 32'(q[0][W]));
         end
         if (invalidate) begin
            q.delete();
         end else begin
            do_push = sif_tvalid && e_rdy;
            do_pop  = mif_tready && e_vld;
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back({sif_tlast, sif_tdata});
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [W-1:0] d, input logic l);
      sif_tvalid = 1'b1;
      sif_tdata  = d;
      sif_tlast  = l;
      tick();
      sif_tvalid = 1'b0;
      sif_tlast  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; sif_tvalid = 1'b0; sif_tdata = '0; sif_tlast = 1'b0;
      mif_tready = 1'b0; invalidate = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_count",   32'(count),        32'd0);
      chk("rst_tready",  32'(sif_tready),   32'd1);
      chk("rst_tvalid",  32'(mif_tvalid),   32'd0);
      chk("rst_aempty",  32'(almost_empty), 32'd1);
      chk("rst_afull",   32'(almost_full),  32'd0);
      tick();

`ifndef AXIS_FIFO_PKT_MODE_EN
      // Fill / drain
      for (int i = 0; i < 5; i++) push_word(W'(16'h11 + i), i == 4);
      @(negedge clk);
      chk("fill_count",  32'(count),       32'd5);
      chk("fill_tready", 32'(sif_tready),  32'd0);
      chk("fill_afull",  32'(almost_full), 32'd1);
      tick();
      mif_tready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("drain_tvalid", 32'(mif_tvalid), 32'd1);
         chk("drain_tdata",  32'(mif_tdata),  32'h11 + 32'(i));
         tick();
      end
      mif_tready = 1'b0;
      @(negedge clk);
      chk("drain_count",  32'(count),        32'd0);
      chk("drain_aempty", 32'(almost_empty), 32'd1);
      tick();

      // Streaming across pointer wrap
      mif_tready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         sif_tvalid = 1'b1;
         sif_tdata  = W'(16'h100 + i);
         @(negedge clk);
         if (i > 0) begin
            chk("stream_count", 32'(count),     32'd1);
            chk("stream_tdata", 32'(mif_tdata), 32'h100 + 32'(i - 1));
         end
         tick();
      end
      sif_tvalid = 1'b0;
      @(negedge clk);
      chk("stream_last", 32'(mif_tdata), 32'h113);
      tick();
      mif_tready = 1'b0;

      // Full with simultaneous pop
      for (int i = 0; i < 5; i++) push_word(W'(16'h21 + i), 1'b0);
      sif_tvalid = 1'b1; sif_tdata = W'(16'hAA); mif_tready = 1'b1;
      @(negedge clk);
      chk("fullpop_tready", 32'(sif_tready), 32'd0);
      chk("fullpop_head",   32'(mif_tdata),  32'h21);
      tick();
      mif_tready = 1'b0;
      @(negedge clk);
      chk("fullpop_count",   32'(count),      32'd4);
      chk("fullpop_tready1", 32'(sif_tready), 32'd1);
      tick();
      sif_tvalid = 1'b0;
      @(negedge clk);
      chk("fullpop_count5", 32'(count), 32'd5);
      tick();
      mif_tready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("fullpop_drain", 32'(mif_tdata), (i == 4) ? 32'hAA : 32'h22 + 32'(i));
         tick();
      end
      mif_tready = 1'b0;

      // Invalidate
      for (int i = 0; i < 3; i++) push_word(W'(16'h31 + i), 1'b0);
      sif_tvalid = 1'b1; sif_tdata = W'(16'h44); mif_tready = 1'b1; invalidate = 1'b1;
      @(negedge clk);
      chk("inv_tready", 32'(sif_tready), 32'd0);
      chk("inv_tvalid", 32'(mif_tvalid), 32'd0);
      tick();
      invalidate = 1'b0; sif_tvalid = 1'b0; mif_tready = 1'b0;
      @(negedge clk);
      chk("inv_count",   32'(count),      32'd0);
      chk("inv_tvalid1", 32'(mif_tvalid), 32'd0);
      tick();
      sif_tvalid = 1'b1; sif_tdata = W'(16'h55);
      @(negedge clk);
      chk("inv_nobypass", 32'(mif_tvalid), 32'd0);
      tick();
      sif_tvalid = 1'b0;
      @(negedge clk);
      chk("inv_55_vld",  32'(mif_tvalid), 32'd1);
      chk("inv_55_data", 32'(mif_tdata),  32'h55);
      tick();
      mif_tready = 1'b1;
      tick();
      mif_tready = 1'b0;

      // Reset mid-operation
      for (int i = 0; i < 4; i++) push_word(W'(16'h61 + i), 1'b0);
      rst = 1'b1; sif_tvalid = 1'b1; sif_tdata = W'(16'h77);
      tick();
      rst = 1'b0; sif_tvalid = 1'b0; mif_tready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst2_count",  32'(count),        32'd0);
         chk("rst2_tvalid", 32'(mif_tvalid),   32'd0);
         chk("rst2_tready", 32'(sif_tready),   32'd1);
         chk("rst2_aempty", 32'(almost_empty), 32'd1);
         tick();
      end
      mif_tready = 1'b0;
`else
      // Three-word packet, tlast on the third
      for (int i = 0; i < 3; i++) begin
         sif_tvalid = 1'b1; sif_tdata = W'(16'h41 + i); sif_tlast = (i == 2);
         @(negedge clk);
         chk("pkt3_hold", 32'(mif_tvalid), 32'd0);
         tick();
      end
      sif_tvalid = 1'b0; sif_tlast = 1'b0; mif_tready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("pkt3_vld",  32'(mif_tvalid), 32'd1);
         chk("pkt3_data", 32'(mif_tdata),  32'h41 + 32'(i));
         chk("pkt3_last", 32'(mif_tlast),  32'(i == 2));
         tick();
      end
      mif_tready = 1'b0;
      @(negedge clk);
      chk("pkt3_empty", 32'(count), 32'd0);
      tick();

      // Eight words without tlast: released only by the full condition
      for (int i = 0; i < 8; i++) begin
         sif_tvalid = 1'b1; sif_tdata = W'(16'h81 + i); sif_tlast = 1'b0;
         @(negedge clk);
         chk("pkt8_hold", 32'(mif_tvalid), 32'd0);
         tick();
      end
      sif_tvalid = 1'b0;
      @(negedge clk);
      chk("pkt8_count", 32'(count),      32'd8);
      chk("pkt8_vld",   32'(mif_tvalid), 32'd1);
      chk("pkt8_data",  32'(mif_tdata),  32'h81);
      tick();
      mif_tready = 1'b1;
      tick();
      mif_tready = 1'b0;
      @(negedge clk);
      chk("pkt8_stall", 32'(mif_tvalid), 32'd0);
      chk("pkt8_cnt7",  32'(count),      32'd7);
      tick();
      push_word(W'(16'h89), 1'b1);
      mif_tready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("pkt8_tail", 32'(mif_tdata), 32'h82 + 32'(i));
         tick();
      end
      mif_tready = 1'b0;
      @(negedge clk);
      chk("pkt8_empty", 32'(count), 32'd0);
      tick();
`endif

      tick();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
